game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 26 ++
 rtl/hold_timer.sv | 34 +++
 rtl/game_flow_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state/control codes and helpers for the game sequencer and the display mux.
package game_pkg;

  localparam int unsigned ID_W    = 16;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned TIMER_W = 32;

  // Encodings double as the display mux control code.
  typedef enum logic [2:0] {
    ST_OUT   = 3'd0,
    ST_LEVEL = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SCORE = 3'd3,
    ST_TOPID = 3'd4,
    ST_TOPSC = 3'd5
  } state_e;

  // Saturate each BCD digit at 9 so a glitchy score cannot show a hex digit.
  function automatic logic [SCORE_W-1:0] bcd_clamp(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    r[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    r[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return r;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter: after a load of N, done is high during the Nth following cycle, then stops.
module hold_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= (load_val == '0) ? '0 : load_val - WIDTH'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      // Stop at zero rather than wrapping.
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - WIDTH'(1);
      end
    end
  end

  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: login, level select, play, timed post-game screens and top-score record.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAME_CYCLES = 1_500_000_000,
  parameter int unsigned MIN_LEN     = 3,
  parameter int unsigned MAX_LEN     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               login_valid,
  input  logic [ID_W-1:0]    login_id,
  input  logic               logout,
  input  logic               btn_next,
  input  logic               btn_start,
  input  logic               game_done,
  input  logic [SCORE_W-1:0] score_bcd,
  output logic [2:0]         ctrl_sig,
  output logic [2:0]         mode_len,
  output logic               game_start,
  output logic [ID_W-1:0]    cur_id,
  output logic [SCORE_W-1:0] last_score,
  output logic [ID_W-1:0]    top_id,
  output logic [SCORE_W-1:0] top_score,
  output logic               new_top
);

  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d, top_id_q, top_id_d;
  logic [SCORE_W-1:0]   last_q, last_d, top_sc_q, top_sc_d;
  logic                 top_valid_q, top_valid_d;
  logic                 game_start_q, game_start_d, new_top_q, new_top_d;
  logic                 timer_load, timer_done;
  logic [TIMER_W-1:0]   timer_val;
  logic [SCORE_W-1:0]   score_clamped;

  assign score_clamped = bcd_clamp(score_bcd);

  hold_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .done    (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cur_id_d     = cur_id_q;
    last_d       = last_q;
    top_id_d     = top_id_q;
    top_sc_d     = top_sc_q;
    top_valid_d  = top_valid_q;
    game_start_d = 1'b0;
    new_top_d    = 1'b0;
    timer_load   = 1'b0;
    timer_val    = TIMER_W'(HOLD_CYCLES);

    // Logout pre-empts everything, including a game ending in the same cycle.
    if (logout && (state_q != ST_OUT)) begin
      state_d  = ST_OUT;
      cur_id_d = '0;
    end else begin
      unique case (state_q)
        ST_OUT: begin
          if (login_valid) begin
            state_d  = ST_LEVEL;
            cur_id_d = login_id;
            mode_d   = 3'(MIN_LEN);
          end
        end
        ST_LEVEL: begin
          if (btn_start) begin
            state_d      = ST_PLAY;
            game_start_d = 1'b1;
            timer_load   = 1'b1;
            timer_val    = TIMER_W'(GAME_CYCLES);
          end else if (btn_next) begin
            mode_d = (mode_q >= 3'(MAX_LEN)) ? 3'(MIN_LEN) : mode_q + 3'd1;
          end
        end
        ST_PLAY: begin
          if (game_done || timer_done) begin
            last_d = score_clamped;
            // Strictly greater: a tie keeps the earlier holder.
            if (!top_valid_q || (score_clamped > top_sc_q)) begin
              top_id_d    = cur_id_q;
              top_sc_d    = score_clamped;
              top_valid_d = 1'b1;
              new_top_d   = 1'b1;
            end
            state_d    = ST_SCORE;
            timer_load = 1'b1;
          end
        end
        ST_SCORE: begin
          if (btn_next || timer_done) begin
            state_d    = ST_TOPID;
            timer_load = 1'b1;
          end
        end
        ST_TOPID: begin
          if (btn_next || timer_done) begin
            state_d    = ST_TOPSC;
            timer_load = 1'b1;
          end
        end
        ST_TOPSC: begin
          if (btn_next || timer_done) begin
            state_d = ST_LEVEL;
          end
        end
        default: state_d = ST_OUT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OUT;
      mode_q       <= 3'(MIN_LEN);
      cur_id_q     <= '0;
      last_q       <= '0;
      top_id_q     <= '0;
      top_sc_q     <= '0;
      top_valid_q  <= 1'b0;
      game_start_q <= 1'b0;
      new_top_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cur_id_q     <= cur_id_d;
      last_q       <= last_d;
      top_id_q     <= top_id_d;
      top_sc_q     <= top_sc_d;
      top_valid_q  <= top_valid_d;
      game_start_q <= game_start_d;
      new_top_q    <= new_top_d;
    end
  end

  assign ctrl_sig   = state_q;
  assign mode_len   = mode_q;
  assign game_start = game_start_q;
  assign cur_id     = cur_id_q;
  assign last_score = last_q;
  assign top_id     = top_id_q;
  assign top_score  = top_sc_q;
  assign new_top    = new_top_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor checks each output change.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        login_valid = 1'b0;
  logic [15:0] login_id = '0;
  logic        logout = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_start = 1'b0;
  logic        game_done = 1'b0;
  logic [7:0]  score_bcd = '0;
  logic [2:0]  ctrl_sig, mode_len;
  logic        game_start, new_top;
  logic [15:0] cur_id, top_id;
  logic [7:0]  last_score, top_score;

  game_flow_ctrl #(
    .HOLD_CYCLES(4),
    .GAME_CYCLES(20),
    .MIN_LEN    (3),
    .MAX_LEN    (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .login_valid(login_valid),
    .login_id   (login_id),
    .logout     (logout),
    .btn_next   (btn_next),
    .btn_start  (btn_start),
    .game_done  (game_done),
    .score_bcd  (score_bcd),
    .ctrl_sig   (ctrl_sig),
    .mode_len   (mode_len),
    .game_start (game_start),
    .cur_id     (cur_id),
    .last_score (last_score),
    .top_id     (top_id),
    .top_score  (top_score),
    .new_top    (new_top)
  );

  always #5 clk = ~clk;

  // dt: cycles since the previous output change (0 = not checked).
  typedef struct {
    int          dt;
    logic [55:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [2:0]  e_ctrl, e_mode;
  logic [15:0] e_cid, e_tid;
  logic [7:0]  e_last, e_tsc;
  logic        e_gs, e_nt;

  task automatic push(input int dt);
    exp_t e;
    e.dt = dt;
    e.v  = {e_ctrl, e_mode, e_cid, e_last, e_tid, e_tsc, e_gs, e_nt};
    exp_q.push_back(e);
  endtask

  task automatic set_reset_exp();
    e_ctrl = 3'd0; e_mode = 3'd3; e_cid = '0; e_last = '0;
    e_tid = '0; e_tsc = '0; e_gs = 1'b0; e_nt = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ctrl(input logic [2:0] target, input int budget);
    int n = 0;
    while (ctrl_sig !== target && n < budget) begin
      step();
      n++;
    end
    if (ctrl_sig !== target) begin
      checks++;
      failures++;
      $display("FAIL wait_ctrl: ctrl_sig=%0d, required %0d within %0d cycles", ctrl_sig, target,
               budget);
    end
  endtask

  task automatic login(input logic [15:0] id);
    e_ctrl = 3'd1; e_cid = id; e_mode = 3'd3;
    push(0);
    login_valid = 1'b1; login_id = id;
    step();
    login_valid = 1'b0;
    step();
  endtask

  task automatic start_game();
    e_ctrl = 3'd2; e_gs = 1'b1;
    push(0);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    e_gs = 1'b0;
    push(1);
    step();
  endtask

  task automatic finish_game(input logic [7:0] score, input logic [7:0] exp_last,
                             input bit upd);
    e_ctrl = 3'd3; e_last = exp_last;
    if (upd) begin
      e_tid = e_cid; e_tsc = exp_last; e_nt = 1'b1;
    end
    push(0);
    game_done = 1'b1; score_bcd = score;
    step();
    game_done = 1'b0;
    if (upd) begin
      e_nt = 1'b0;
      push(1);
    end
  endtask

  task automatic screens(input int d4);
    e_ctrl = 3'd4; push(d4);
    e_ctrl = 3'd5; push(4);
    e_ctrl = 3'd1; push(4);
    wait_ctrl(3'd1, 40);
  endtask

  // Monitor: every change of the output vector consumes one expected snapshot.
  initial begin
    logic [55:0] cur, prev;
    exp_t        e;
    int          cyc, last_chg, evt;
    prev = 'x; cyc = 0; last_chg = 0; evt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {ctrl_sig, mode_len, cur_id, last_score, top_id, top_score, game_start, new_top};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change evt%0d: got %h, required no change from %h", evt, cur,
                   prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v) begin
            failures++;
            $display({"FAIL outputs evt%0d: got ctrl=%0d mode=%0d cur_id=%h last=%h top_id=%h ",
                      "top_score=%h gs=%b nt=%b, required ctrl=%0d mode=%0d cur_id=%h last=%h ",
                      "top_id=%h top_score=%h gs=%b nt=%b"}, evt,
                     cur[55:53], cur[52:50], cur[49:34], cur[33:26], cur[25:10], cur[9:2],
                     cur[1], cur[0], e.v[55:53], e.v[52:50], e.v[49:34], e.v[33:26],
                     e.v[25:10], e.v[9:2], e.v[1], e.v[0]);
          end
          if (e.dt > 0) begin
            checks++;
            if (cyc - last_chg != e.dt) begin
              failures++;
              $display("FAIL timing evt%0d: got %0d cycles since last change, required %0d", evt,
                       cyc - last_chg, e.dt);
            end
          end
        end
        prev = cur; last_chg = cyc; evt++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, required finish before 20000 ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    set_reset_exp();
    push(0);
    step(); step();
    rst = 1'b0;

    // Login and level wrap 4,5,6,3
    login(16'h1234);
    for (int i = 0; i < 4; i++) begin
      e_mode = (i == 3) ? 3'd3 : 3'(4 + i);
      push(0);
      btn_next = 1'b1;
      step();
      btn_next = 1'b0;
      step();
    end

    // First game sets the record
    start_game();
    finish_game(8'h42, 8'h42, 1'b1);
    screens(3);

    // Second player: tie keeps holder, then beats it; skip SHOW_SCORE
    e_ctrl = 3'd0; e_cid = '0; push(0);
    logout = 1'b1; step(); logout = 1'b0; step();
    btn_start = 1'b1; step(); btn_start = 1'b0; step();
    login(16'hBEEF);
    start_game();
    finish_game(8'h42, 8'h42, 1'b0);
    screens(4);
    start_game();
    finish_game(8'h57, 8'h57, 1'b1);
    step();
    e_ctrl = 3'd4; push(1);
    btn_next = 1'b1; step(); btn_next = 1'b0;
    e_ctrl = 3'd5; push(4);
    e_ctrl = 3'd1; push(4);
    wait_ctrl(3'd1, 40);

    // Timeout with clamped score; buttons ignored while playing
    e_mode = 3'd4; push(0);
    btn_next = 1'b1; step(); btn_next = 1'b0; step();
    score_bcd = 8'h0F;
    start_game();
    e_ctrl = 3'd3; e_last = 8'h09; push(19);
    btn_next = 1'b1; step(); btn_next = 1'b0; step();
    btn_start = 1'b1; step(); btn_start = 1'b0;
    screens(4);

    // Start beats next; logout beats game_done
    e_ctrl = 3'd2; e_gs = 1'b1; push(0);
    btn_start = 1'b1; btn_next = 1'b1; step(); btn_start = 1'b0; btn_next = 1'b0;
    e_gs = 1'b0; push(1); step();
    e_ctrl = 3'd0; e_cid = '0; push(0);
    logout = 1'b1; game_done = 1'b1; score_bcd = 8'h99;
    step();
    logout = 1'b0; game_done = 1'b0;
    step();
    login(16'h1234);

    // Reset during SHOW_TOP_ID clears the record too
    start_game();
    finish_game(8'h10, 8'h10, 1'b0);
    e_ctrl = 3'd4; push(4);
    wait_ctrl(3'd4, 20);
    set_reset_exp(); push(0);
    rst = 1'b1; step(); rst = 1'b0; step();

    // With no record, even a low score takes it; high nibble clamps
    login(16'hABCD);
    start_game();
    finish_game(8'hC0, 8'h90, 1'b1);
    screens(3);

    step(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected changes never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
